// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the PC sequencer and its fetch/decode neighbours.
// master drives instruction-side inputs, slave is the sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [31:0]       instr;
  logic              instr_valid;
  logic              branch_taken;
  logic [ADDR_W-1:0] rs_value;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] ras_top;
  logic [CW-1:0]     ras_count;
  logic              ras_mismatch;
  logic              addr_err;

  modport master (
    output instr, instr_valid, branch_taken,
    output rs_value, stall,
    output redirect_valid, redirect_pc,
    input  pc, link_addr, ras_top,
    input  ras_count, ras_mismatch, addr_err
  );

  modport slave (
    input  instr, instr_valid, branch_taken,
    input  rs_value, stall,
    input  redirect_valid, redirect_pc,
    output pc, link_addr, ras_top,
    output ras_count, ras_mismatch, addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program counter: sequential/jump/branch/register targets,
// stall, redirect, misaligned-target trap and a return-address checker.
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int          RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LOW2 = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RV =
    ADDR_W'(RESET_VECTOR) & ~LOW2;
  localparam logic [ADDR_W-1:0] EV =
    ADDR_W'(EXC_VECTOR) & ~LOW2;
  localparam logic [ADDR_W-1:0] HI =
    ADDR_W'(32'hF000_0000);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     top_idx;
  logic [CW-1:0]     count;
  logic              mis_q;
  logic              err_q;

  logic [5:0] op;
  logic [5:0] fn;
  logic       is_j;
  logic       is_jal;
  logic       is_br;
  logic       is_jr;
  logic       is_jalr;
  logic       jreg;
  logic       misal;
  logic       jgo;
  logic       push;
  logic       pop;
  logic       mis_nxt;

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] jump;
  logic [ADDR_W-1:0] branch;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] nxt;

  assign op = bus.instr[31:26];
  assign fn = bus.instr[5:0];

  assign is_j    = bus.instr_valid & (op == 6'b000010);
  assign is_jal  = bus.instr_valid & (op == 6'b000011);
  assign is_br   = bus.instr_valid &
                   ((op == 6'b000100) | (op == 6'b000101));
  assign is_jr   = bus.instr_valid & (op == 6'b000000) &
                   (fn == 6'b001000);
  assign is_jalr = bus.instr_valid & (op == 6'b000000) &
                   (fn == 6'b001001);

  assign jreg  = is_jr | is_jalr;
  assign misal = jreg & (|bus.rs_value[1:0]);
  assign jgo   = jreg & ~misal;

  assign seq  = pc_q + ADDR_W'(4);
  assign jump = (seq & HI) |
                ADDR_W'({bus.instr[25:0], 2'b00});
  assign branch = seq + ADDR_W'({{14{bus.instr[15]}},
                                 bus.instr[15:0], 2'b00});

  assign top_idx = wptr - PW'(1);
  assign top     = (count == '0) ? '0 : ras[top_idx];

  // Only JR $ra is checked; JALR $ra still pushes.
  assign push = is_jal | (is_jalr & ~misal);
  assign pop  = is_jr & ~misal &
                (bus.instr[25:21] == 5'd31) &
                (count != '0);
  assign mis_nxt = pop & (bus.rs_value != top);

  always_comb begin
    nxt = seq;
    unique case (1'b1)
      misal:          nxt = EV;
      is_j | is_jal:  nxt = jump;
      jgo:            nxt = bus.rs_value;
      is_br & bus.branch_taken:
                      nxt = branch;
      default:        nxt = seq;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RV;
      wptr  <= '0;
      count <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      pc_q  <= bus.redirect_pc & ~LOW2;
      wptr  <= '0;
      count <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.stall) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= nxt;
      mis_q <= mis_nxt;
      err_q <= misal;
      if (push) begin
        // Oldest entry is overwritten once full.
        ras[wptr] <= seq;
        wptr      <= wptr + PW'(1);
        if (count != CW'(RAS_DEPTH)) begin
          count <= count + CW'(1);
        end
      end else if (pop) begin
        wptr  <= top_idx;
        count <= count - CW'(1);
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.link_addr    = seq;
  assign bus.ras_top      = top;
  assign bus.ras_count    = count;
  assign bus.ras_mismatch = mis_q;
  assign bus.addr_err     = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a queue-based reference
// model, plus literal checks and a 16-bit wrap instance.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(32), .RAS_DEPTH(4)) b();
  pc_sequencer_if #(.ADDR_W(16), .RAS_DEPTH(4)) h();

  pc_sequencer #(
    .ADDR_W(32), .RESET_VECTOR(32'h0),
    .EXC_VECTOR(32'h180), .RAS_DEPTH(4)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  pc_sequencer #(
    .ADDR_W(16), .RESET_VECTOR(32'h0),
    .EXC_VECTOR(32'h180), .RAS_DEPTH(4)
  ) dut16 (.clk(clk), .rst_n(rst_n), .bus(h));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_mis;
  bit          m_err;

  localparam logic [31:0] NOP  = 32'h0;
  localparam logic [31:0] JR31 = {6'd0, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] JR1  = {6'd0, 5'd1, 15'd0, 6'h08};
  localparam logic [31:0] JALR = {6'd0, 5'd5, 5'd0, 5'd31,
                                  5'd0, 6'h09};

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void m_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_mis = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void m_push(logic [31:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > 4) void'(m_ras.pop_front());
  endfunction

  // Architectural effect of one clock edge.
  task automatic model_edge(logic [31:0] i, bit v, bit bt,
                            logic [31:0] rs, bit st, bit rv,
                            logic [31:0] rp);
    logic [31:0] s;
    logic [5:0]  o;
    bit jr, jalr;
    s = m_pc + 32'd4;
    o = i[31:26];
    jr   = v && o == 0 && i[5:0] == 6'h08;
    jalr = v && o == 0 && i[5:0] == 6'h09;
    m_mis = 1'b0;
    m_err = 1'b0;
    if (rv) begin
      m_pc = rp & ~32'd3;
      m_ras.delete();
    end else if (st) begin
      m_pc = m_pc;
    end else if ((jr || jalr) && rs[1:0] != 0) begin
      m_pc = 32'h180;
      m_err = 1'b1;
    end else if (v && (o == 2 || o == 3)) begin
      m_pc = {s[31:28], i[25:0], 2'b00};
      if (o == 3) m_push(s);
    end else if (jr || jalr) begin
      if (jalr) m_push(s);
      if (jr && i[25:21] == 31 && m_ras.size() > 0) begin
        if (m_ras[$] != rs) m_mis = 1'b1;
        void'(m_ras.pop_back());
      end
      m_pc = rs;
    end else if (v && (o == 4 || o == 5) && bt) begin
      m_pc = s + {{14{i[15]}}, i[15:0], 2'b00};
    end else begin
      m_pc = s;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", b.pc, m_pc);
      chk("link", b.link_addr, m_pc + 32'd4);
      chk("ras_count", 32'(b.ras_count), m_ras.size());
      chk("ras_top", b.ras_top,
          m_ras.size() == 0 ? 32'h0 : m_ras[$]);
      chk("mismatch", 32'(b.ras_mismatch), 32'(m_mis));
      chk("addr_err", 32'(b.addr_err), 32'(m_err));
    end
  end

  task automatic step(logic [31:0] i, bit v, bit bt,
                      logic [31:0] rs, bit st, bit rv,
                      logic [31:0] rp);
    b.instr = i;
    b.instr_valid = v;
    b.branch_taken = bt;
    b.rs_value = rs;
    b.stall = st;
    b.redirect_valid = rv;
    b.redirect_pc = rp;
    @(posedge clk);
    model_edge(i, v, bt, rs, st, rv, rp);
    @(negedge clk);
  endtask

  task automatic op(logic [31:0] i, logic [31:0] rs);
    step(i, 1'b1, 1'b0, rs, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic redir(logic [31:0] a);
    step(NOP, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a);
  endtask

  logic [31:0] beq_m1;
  logic [31:0] jal_a;
  logic [31:0] r, ri, rsv, rp;
  logic [4:0]  rsf;
  bit          rv_b, st_b, v_b, bt_b;

  initial begin
    beq_m1 = {6'd4, 5'd1, 5'd2, 16'hFFFF};
    jal_a  = {6'd3, 26'h100};
    b.instr = '0; b.instr_valid = 0; b.branch_taken = 0;
    b.rs_value = '0; b.stall = 0;
    b.redirect_valid = 0; b.redirect_pc = '0;
    h.instr = '0; h.instr_valid = 0; h.branch_taken = 0;
    h.rs_value = '0; h.stall = 0;
    h.redirect_valid = 0; h.redirect_pc = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_pc", b.pc, 32'h0);
    chk("rst_cnt", 32'(b.ras_count), 32'h0);

    h.redirect_valid = 1'b1;
    h.redirect_pc = 16'hFFF3;
    step(NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("seq1", b.pc, 32'h4);
    chk("w16_redir", 32'(h.pc), 32'hFFF0);
    h.redirect_valid = 1'b0;
    h.instr = {6'd4, 5'd1, 5'd2, 16'h7FFF};
    h.instr_valid = 1'b1;
    h.branch_taken = 1'b1;
    step(NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("seq2", b.pc, 32'h8);
    chk("w16_beq", 32'(h.pc), 32'hFFF0);
    chk("w16_link", 32'(h.link_addr), 32'hFFF4);
    h.instr = {6'd2, 26'h40};
    step(NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("seq3", b.pc, 32'hC);
    chk("w16_j", 32'(h.pc), 32'h0100);
    h.instr_valid = 1'b0;

    redir(32'h1000_0010);
    op({6'd2, 26'h40}, 0); #1;
    chk("j_tgt", b.pc, 32'h1000_0100);

    redir(32'h20);
    step(beq_m1, 1, 1, 0, 0, 0, 0); #1;
    chk("beq_tk", b.pc, 32'h20);
    step(beq_m1, 1, 0, 0, 0, 0, 0); #1;
    chk("beq_nt", b.pc, 32'h24);

    redir(32'h40);
    op(jal_a, 0);
    step(jal_a, 1, 0, 0, 1, 0, 0);
    step(jal_a, 1, 0, 0, 1, 0, 0); #1;
    chk("stall_pc", b.pc, 32'h400);
    chk("stall_cnt", 32'(b.ras_count), 32'h1);
    step(jal_a, 1, 0, 0, 1, 1, 32'h203); #1;
    chk("redir_pc", b.pc, 32'h200);
    chk("redir_cnt", 32'(b.ras_count), 32'h0);

    redir(32'h40);
    op(jal_a, 0); #1;
    chk("jal_top", b.ras_top, 32'h44);
    op(JR31, 32'h44); #1;
    chk("ret_pc", b.pc, 32'h44);
    chk("ret_mis", 32'(b.ras_mismatch), 32'h0);
    chk("ret_cnt", 32'(b.ras_count), 32'h0);
    redir(32'h40);
    op(jal_a, 0);
    op(JR31, 32'h48); #1;
    chk("mis_pulse", 32'(b.ras_mismatch), 32'h1);
    op(NOP, 0); #1;
    chk("mis_clear", 32'(b.ras_mismatch), 32'h0);
    op(JR31, 32'h100); #1;
    chk("empty_mis", 32'(b.ras_mismatch), 32'h0);

    for (int k = 1; k <= 5; k++) begin
      op({6'd3, 26'h800}, 0);
      if (k < 5) op(JR1, 32'((k + 1) * 256));
    end
    #1;
    chk("ovf_cnt", 32'(b.ras_count), 32'h4);
    chk("ovf_top", b.ras_top, 32'h504);
    for (int k = 5; k >= 2; k--) begin
      op(JR31, 32'(k * 256 + 4)); #1;
      chk("ovf_pop", 32'(b.ras_mismatch), 32'h0);
    end
    chk("ovf_empty", 32'(b.ras_count), 32'h0);

    op(jal_a, 0);
    op(JALR, 32'h102); #1;
    chk("mal_pc", b.pc, 32'h180);
    chk("mal_err", 32'(b.addr_err), 32'h1);
    chk("mal_cnt", 32'(b.ras_count), 32'h1);
    op(NOP, 0); #1;
    chk("mal_clr", 32'(b.addr_err), 32'h0);

    #3 rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_pc", b.pc, 32'h0);
    chk("arst_cnt", 32'(b.ras_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0: ri = NOP;
        1: ri = r;
        2: ri = {6'd2, r[25:0]};
        3: ri = {6'd3, r[25:0]};
        4: ri = {6'd4, r[25:0]};
        5: ri = {6'd5, r[25:0]};
        6, 7: begin
          rsf = ($urandom_range(0, 3) != 0) ? 5'd31 : r[25:21];
          ri = {6'd0, rsf, r[20:6], 6'h08};
        end
        8: ri = {6'd0, r[25:6], 6'h09};
        default: ri = {6'd0, r[25:6], r[5:0]};
      endcase
      rsv = $urandom & ~32'd3;
      if (m_ras.size() > 0 && $urandom_range(0, 1) == 1)
        rsv = m_ras[$];
      if ($urandom_range(0, 9) == 0)
        rsv[1:0] = 2'($urandom_range(1, 3));
      v_b  = $urandom_range(0, 9) != 0;
      bt_b = $urandom_range(0, 1) == 1;
      st_b = $urandom_range(0, 9) == 0;
      rv_b = $urandom_range(0, 19) == 0;
      rp   = $urandom;
      step(ri, v_b, bt_b, rsv, st_b, rv_b, rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
